// File: rtl/bus_node_pkg.sv
// Shared constants and packet field helpers for the bus node endpoint.
// Packets are {dest_id[7:0], payload}; helpers take the packet zero-extended to PKT_MAX_W.
package bus_node_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
    localparam int PKT_MAX_W = 256;

    function automatic logic [ID_W-1:0] pkt_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int pckg_sz);
        return ID_W'(pkt >> (pckg_sz - ID_W));
    endfunction

    function automatic logic [PKT_MAX_W-1:0] pkt_payload(input logic [PKT_MAX_W-1:0] pkt,
                                                         input int pckg_sz);
        logic [PKT_MAX_W-1:0] mask;
        mask = (PKT_MAX_W'(1) << (pckg_sz - ID_W)) - PKT_MAX_W'(1);
        return pkt & mask;
    endfunction

endpackage

// File: rtl/bus_node_fifo_sync.sv
// First-word-fall-through synchronous FIFO with registered head, occupancy count and write-drop flag.
// WR_THRU_FULL lets a write land while full when a read retires in the same cycle.
module node_sync_fifo #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 8,
    parameter bit WR_THRU_FULL = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_req,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd_req,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     wr_drop
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_en   = rd_req && !empty;
    assign wr_en   = wr_req && (!full || (WR_THRU_FULL && rd_en));
    assign wr_drop = wr_req && !wr_en;
    assign head    = head_q;
    assign count   = count_q;

    // Head is registered so it holds the last value when the FIFO drains.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        head_d   = head_q;
        if (count_d != '0) begin
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                head_d = wdata;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/bus_node_fifo.sv
// Bus node endpoint: TX FIFO toward the bus, RX FIFO from the bus, sticky error flags.
// Optional destination filter on received packets: BUS_NODE_ADDR_FILTER_EN.
module bus_node_fifo
    import bus_node_pkg::*;
#(
    parameter int         PCKG_SZ   = 16,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] ID        = 8'h00,
    parameter logic [7:0] BROADCAST = BROADCAST_ID
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_valid,
    input  logic [PCKG_SZ-1:0]     tx_data,
    output logic                   tx_ready,
    output logic                   pndng,
    output logic [PCKG_SZ-1:0]     D_pop,
    input  logic                   pop,
    input  logic                   push,
    input  logic [PCKG_SZ-1:0]     D_push,
    output logic                   rx_valid,
    output logic [PCKG_SZ-1:0]     rx_data,
    input  logic                   rx_rd,
    output logic [$clog2(DEPTH):0] tx_cnt,
    output logic [$clog2(DEPTH):0] rx_cnt,
    output logic                   rx_overflow,
`ifdef BUS_NODE_ADDR_FILTER_EN
    output logic [7:0]             filt_drop_cnt,
`endif
    output logic                   pop_underflow
);
    logic tx_full, tx_empty, tx_drop_unused;
    logic rx_full_unused, rx_empty, rx_wr_drop;
    logic rx_wr_req;
    logic rx_overflow_q, rx_overflow_d;
    logic pop_underflow_q, pop_underflow_d;

    node_sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH), .WR_THRU_FULL(1'b0)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_req  (tx_valid),
        .wdata   (tx_data),
        .rd_req  (pop),
        .head    (D_pop),
        .count   (tx_cnt),
        .full    (tx_full),
        .empty   (tx_empty),
        .wr_drop (tx_drop_unused)
    );

    node_sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH), .WR_THRU_FULL(1'b1)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_req  (rx_wr_req),
        .wdata   (D_push),
        .rd_req  (rx_rd),
        .head    (rx_data),
        .count   (rx_cnt),
        .full    (rx_full_unused),
        .empty   (rx_empty),
        .wr_drop (rx_wr_drop)
    );

    assign tx_ready = !tx_full;
    assign pndng    = !tx_empty;
    assign rx_valid = !rx_empty;

`ifdef BUS_NODE_ADDR_FILTER_EN
    logic [7:0] push_dest;
    logic       addr_match;
    logic [7:0] filt_drop_cnt_q, filt_drop_cnt_d;

    assign push_dest     = pkt_dest(PKT_MAX_W'(D_push), PCKG_SZ);
    assign addr_match    = (push_dest == ID) || (push_dest == BROADCAST);
    assign rx_wr_req     = push && addr_match;
    assign filt_drop_cnt = filt_drop_cnt_q;

    always_comb begin
        filt_drop_cnt_d = filt_drop_cnt_q;
        if (push && !addr_match && (filt_drop_cnt_q != 8'hFF)) begin
            filt_drop_cnt_d = filt_drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_drop_cnt_q <= '0;
        end else begin
            filt_drop_cnt_q <= filt_drop_cnt_d;
        end
    end
`else
    logic [15:0] addr_params_unused;
    assign addr_params_unused = {ID, BROADCAST};
    assign rx_wr_req          = push;
`endif

    // Filtered packets never reach the RX FIFO, so they cannot raise overflow.
    always_comb begin
        rx_overflow_d   = rx_overflow_q || rx_wr_drop;
        pop_underflow_d = pop_underflow_q || (pop && tx_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overflow_q   <= 1'b0;
            pop_underflow_q <= 1'b0;
        end else begin
            rx_overflow_q   <= rx_overflow_d;
            pop_underflow_q <= pop_underflow_d;
        end
    end

    assign rx_overflow   = rx_overflow_q;
    assign pop_underflow = pop_underflow_q;

endmodule
